round_key_store: RTL and testbench
==================================

ROUND_KEY_STORE -- requirements
Module: round_key_store

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of one round key in bits.
REQ-002 SHALL have parameter NUM_KEYS, default 15, number of stored round keys (AES-256: 14 rounds + initial).
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_KEYS), key index width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  load strobe for one round key.
REQ-007 wr_addr  input  ADDR_W  key index to load.
REQ-008 wr_data  input  DATA_W  round key value to load.
REQ-009 start  input  1  request to stream all keys.
REQ-010 dir  input  1  stream order, sampled with start: 0 = ascending (encrypt), 1 = descending (decrypt).
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 out_valid  output  1  out_data/out_idx hold a valid key.
REQ-013 out_data  output  DATA_W  streamed round key.
REQ-014 out_idx  output  ADDR_W  storage index of the key on out_data.
REQ-015 busy  output  1  stream in progress.
REQ-016 done  output  1  one-cycle pulse after the final key is accepted.
REQ-017 err  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-018 SHALL keep NUM_KEYS x DATA_W storage plus a NUM_KEYS-bit loaded mask.
REQ-019 In IDLE, wr_en with wr_addr < NUM_KEYS SHALL write wr_data and set loaded[wr_addr] at the clock edge.
REQ-020 wr_en with wr_addr >= NUM_KEYS SHALL not write and SHALL pulse err the next cycle.
REQ-021 wr_en while busy SHALL not write and SHALL pulse err the next cycle.
REQ-022 FSM states: IDLE, STREAM, FINISH; IDLE -> STREAM on accepted start; STREAM -> FINISH on handshake of last key; FINISH -> IDLE unconditionally after one cycle.
REQ-023 start in IDLE SHALL be accepted only when every loaded bit is set; otherwise no stream, err pulse next cycle.
REQ-024 start while busy or in FINISH SHALL be ignored and SHALL pulse err the next cycle.
REQ-025 start and wr_en in the same IDLE cycle: write performed, start evaluated with the updated loaded mask, stream returns the newly written value.
REQ-026 First key SHALL appear with out_valid=1 exactly one cycle after the accepted start: index 0 if dir=0, NUM_KEYS-1 if dir=1.
REQ-027 Handshake = out_valid & out_ready; on handshake index advances by +1 (dir=0) or -1 (dir=1).
REQ-028 With out_ready held high SHALL deliver one key per cycle, no bubbles (NUM_KEYS consecutive valid cycles).
REQ-029 While out_valid & !out_ready, out_data and out_idx SHALL stay stable.
REQ-030 out_valid SHALL deassert in the cycle after the last handshake; done SHALL be high in that same cycle (FINISH) only.
REQ-031 out_data SHALL be zero whenever out_valid=0.
REQ-032 busy SHALL be 1 in STREAM and FINISH, 0 in IDLE.
REQ-033 dir SHALL be latched at start; changes mid-stream have no effect.

Reset
REQ-034 rst SHALL force IDLE, clear loaded mask, and drive out_valid, out_data, out_idx, busy, done, err to 0 on the next edge.
REQ-035 rst mid-stream SHALL abort with no done pulse; key storage contents need not be cleared but are unusable until reloaded.

Structure
REQ-036 State enum and default DATA_W/NUM_KEYS constants SHALL live in the shared AES package.
REQ-037 Storage SHALL be a sub-module key_ram (1 write port, 1 synchronous read port); FSM, counter and handshake in round_key_store.

Verification
REQ-038 Load keys k[i]=i*0x0101..01 for i=0..14, start dir=0, out_ready=1 -> 15 consecutive valid cycles, idx 0..14, data k[0]..k[14], done one cycle after idx 14.
REQ-039 Same load, start dir=1 -> idx 14 down to 0 with matching data, done pulse.
REQ-040 Load only 14 keys, start -> no out_valid, err=1 one cycle, busy stays 0.
REQ-041 Stream dir=0 with out_ready low for 3 cycles at idx 5 -> idx 5 and k[5] held stable 3 cycles, then continue at 6.
REQ-042 wr_en addr 15 in IDLE and wr_en addr 3 during stream -> err pulse each, key 3 unchanged in subsequent stream.
REQ-043 rst asserted at idx 7 -> all outputs 0 next cycle, no done; start without reload -> err.

Source files
------------

// File: rtl/round_key_store_pkg.sv
// Shared AES key-schedule definitions: default key geometry and the
// streaming FSM state type used by round_key_store.
package round_key_store_pkg;

    // One 128-bit round key per AES round.
    localparam int unsigned AES_KEY_W    = 128;

    // AES-256 uses 14 rounds plus the initial whitening key.
    localparam int unsigned AES_NUM_KEYS = 15;

    // Stream controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } rks_state_e;

endpackage

// File: rtl/round_key_store_key_ram.sv
// Round-key storage: one write port, one registered read port.
// A read that targets the address being written in the same cycle
// returns the new data, so a key loaded together with a start request
// is the one that gets streamed.
module key_ram
    import round_key_store_pkg::*;
#(
    parameter int unsigned DATA_W = AES_KEY_W,
    parameter int unsigned DEPTH  = AES_NUM_KEYS,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Storage array; contents are never reset, validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next read data: hold unless a read is requested, write-first on collision.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            if (we && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem_q[rd_addr];
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/round_key_store.sv
// Round-key store: accepts round keys one at a time, then streams the
// whole set in ascending (encrypt) or descending (decrypt) order over a
// valid/ready interface. Invalid requests are rejected with an err pulse.
module round_key_store
    import round_key_store_pkg::*;
#(
    parameter int unsigned DATA_W   = AES_KEY_W,
    parameter int unsigned NUM_KEYS = AES_NUM_KEYS,
    parameter int unsigned ADDR_W   = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              dir,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_KEYS - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    rks_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                dir_q, dir_d;
    logic [NUM_KEYS-1:0] loaded_q, loaded_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                wr_in_range;
    logic                handshake;
    logic                at_last;
    logic                ram_we;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_rd_addr;
    logic [DATA_W-1:0]   ram_rd_data;

    key_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_KEYS),
        .ADDR_W (ADDR_W)
    ) u_key_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .re      (ram_re),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // Next-state logic for the load/stream controller. The RAM read for the
    // next key is issued on the same edge that advances idx, so data and
    // index land together one cycle later.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dir_d       = dir_q;
        loaded_d    = loaded_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_rd_addr = idx_q;

        wr_in_range = (32'(wr_addr) < NUM_KEYS);
        handshake   = out_valid_q & out_ready;
        at_last     = dir_q ? (idx_q == '0) : (idx_q == LAST_IDX);

        unique case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (wr_in_range) begin
                        ram_we            = 1'b1;
                        loaded_d[wr_addr] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Start sees the mask including a same-cycle write.
                if (start) begin
                    if (&loaded_d) begin
                        state_d     = STREAM;
                        dir_d       = dir;
                        idx_d       = dir ? LAST_IDX : '0;
                        ram_re      = 1'b1;
                        ram_rd_addr = idx_d;
                        out_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            STREAM: begin
                if (wr_en || start) begin
                    err_d = 1'b1;
                end
                if (handshake) begin
                    if (at_last) begin
                        state_d     = FINISH;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d       = dir_q ? (idx_q - ONE_IDX) : (idx_q + ONE_IDX);
                        ram_re      = 1'b1;
                        ram_rd_addr = idx_d;
                    end
                end
            end

            FINISH: begin
                if (wr_en || start) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);

        if (rst) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dir_q       <= 1'b0;
            loaded_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            loaded_q    <= loaded_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Key data is only exposed while valid; otherwise the bus reads zero.
    always_comb begin
        out_data = out_valid_q ? ram_rd_data : '0;
    end

    assign out_valid = out_valid_q;
    assign out_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_round_key_store.sv
// Randomized self-checking bench for round_key_store against a simple
// array-based model of the stored keys and their loaded status.
module tb_round_key_store;

    localparam int unsigned DW = 128;
    localparam int unsigned NK = 15;
    localparam int unsigned AW = $clog2(NK);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          dir;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_key    [NK];
    bit            model_loaded [NK];

    round_key_store #(
        .DATA_W   (DW),
        .NUM_KEYS (NK),
        .ADDR_W   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .dir       (dir),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_quiet_idle(input string tag);
        check({tag, "_valid"}, DW'(out_valid), DW'(0));
        check({tag, "_data"},  out_data,       DW'(0));
        check({tag, "_busy"},  DW'(busy),      DW'(0));
        check({tag, "_done"},  DW'(done),      DW'(0));
    endtask

    // Load one key from IDLE; out-of-range indices must be refused with err.
    task automatic load_key(input int unsigned i, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(i);
        wr_data = d;
        if (i < NK) begin
            model_key[i]    = d;
            model_loaded[i] = 1'b1;
        end
        tick();
        wr_en = 1'b0;
        check("load_err", DW'(err), DW'(i >= NK));
    endtask

    // Start with an incomplete key set must be refused.
    task automatic attempt_start_fail();
        start = 1'b1;
        dir   = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        check("nostart_err",   DW'(err),       DW'(1));
        check("nostart_valid", DW'(out_valid), DW'(0));
        check("nostart_busy",  DW'(busy),      DW'(0));
        tick();
        check("nostart_err2",  DW'(err),       DW'(0));
        check_quiet_idle("nostart");
    endtask

    // mode 0: ready always high; 1: ready low 3 cycles at position 5;
    // 2: random ready plus random illegal requests; 3: ready high plus a
    // write to key 3 while streaming. abort_at >= 0 asserts rst there.
    task automatic run_stream(input bit d, input int mode, input int abort_at);
        int pos;
        int stall;
        int cyc;
        int exp_idx;
        bit inj;
        bit inj_prev;
        bit finished;
        pos      = 0;
        stall    = 0;
        cyc      = 0;
        inj_prev = 1'b0;
        finished = 1'b0;

        start     = 1'b1;
        dir       = d;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("start_err", DW'(err), DW'(0));

        while (!finished && cyc < 400) begin
            cyc++;
            check("err_pulse", DW'(err), DW'(inj_prev));
            wr_en = 1'b0;
            start = 1'b0;
            inj   = 1'b0;
            if (pos < int'(NK)) begin
                exp_idx = d ? (int'(NK) - 1 - pos) : pos;
                check("valid", DW'(out_valid), DW'(1));
                check("idx",   DW'(out_idx),   DW'(exp_idx));
                check("data",  out_data,       model_key[exp_idx]);
                check("done",  DW'(done),      DW'(0));
                check("busy",  DW'(busy),      DW'(1));
                if (pos == abort_at) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    for (int k = 0; k < int'(NK); k++) model_loaded[k] = 1'b0;
                    check("abort_valid", DW'(out_valid), DW'(0));
                    check("abort_data",  out_data,       DW'(0));
                    check("abort_idx",   DW'(out_idx),   DW'(0));
                    check("abort_busy",  DW'(busy),      DW'(0));
                    check("abort_done",  DW'(done),      DW'(0));
                    check("abort_err",   DW'(err),       DW'(0));
                    tick();
                    check_quiet_idle("abort_after");
                    return;
                end
                case (mode)
                    1: begin
                        if (pos == 5 && stall < 3) begin
                            out_ready = 1'b0;
                            stall++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                    2: out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = 1'b1;
                endcase
                if (out_ready) pos++;
            end else begin
                check("fin_valid", DW'(out_valid), DW'(0));
                check("fin_data",  out_data,       DW'(0));
                check("fin_done",  DW'(done),      DW'(1));
                check("fin_busy",  DW'(busy),      DW'(1));
                finished = 1'b1;
            end
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                inj = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    start = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = AW'($urandom_range(0, (1 << AW) - 1));
                    wr_data = rand_key();
                end
            end else if (mode == 3 && cyc == 3) begin
                inj     = 1'b1;
                wr_en   = 1'b1;
                wr_addr = AW'(3);
                wr_data = ~model_key[3];
            end
            // Direction changes after start must not matter.
            dir      = 1'($urandom_range(0, 1));
            inj_prev = inj;
            tick();
        end
        if (!finished) check("stream_timeout", DW'(0), DW'(1));
        wr_en = 1'b0;
        start = 1'b0;
        check("post_err", DW'(err), DW'(inj_prev));
        check_quiet_idle("post");
        tick();
        check("post_err2", DW'(err), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] ones;
        int            skip;
        ones      = {(DW / 8){8'h01}};
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        dir       = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < int'(NK); k++) begin
            model_key[k]    = '0;
            model_loaded[k] = 1'b0;
        end
        tick();
        tick();
        check("rst_valid", DW'(out_valid), DW'(0));
        check("rst_data",  out_data,       DW'(0));
        check("rst_idx",   DW'(out_idx),   DW'(0));
        check("rst_busy",  DW'(busy),      DW'(0));
        check("rst_done",  DW'(done),      DW'(0));
        check("rst_err",   DW'(err),       DW'(0));
        rst = 1'b0;
        tick();

        // Key i = i * 0x0101..01; then an out-of-range load.
        for (int unsigned i = 0; i < NK; i++) load_key(i, ones * DW'(i));
        load_key(15, rand_key());
        tick();
        check("err_single", DW'(err), DW'(0));

        run_stream(1'b0, 0, -1);
        run_stream(1'b1, 0, -1);
        run_stream(1'b0, 1, -1);
        run_stream(1'b0, 3, -1);
        run_stream(1'b1, 0, -1);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) load_key($urandom_range(0, NK - 1), rand_key());
            run_stream(1'($urandom_range(0, 1)), 2, -1);
        end

        run_stream(1'b0, 0, 7);
        attempt_start_fail();

        skip = int'($urandom_range(0, NK - 1));
        for (int unsigned i = 0; i < NK; i++) begin
            if (int'(i) != skip) load_key(i, rand_key());
        end
        attempt_start_fail();

        // Missing key written in the same cycle as start.
        wr_en                 = 1'b1;
        wr_addr               = AW'(skip);
        wr_data               = rand_key();
        model_key[skip]       = wr_data;
        model_loaded[skip]    = 1'b1;
        run_stream(1'($urandom_range(0, 1)), 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
